// File: rtl/hdlc_deframer_if.sv
// hdlc_deframer_if
// Byte stream leaving the HDLC deframer (valid/ready handshake).
//   m_data  : assembled byte
//   m_sof   : m_data is the first byte of a frame
//   m_valid : byte available
//   m_ready : consumer accepts the byte when m_valid && m_ready
// master = producer (deframer), slave = consumer (e.g. FCS checker).
`timescale 1ns/1ps

interface hdlc_deframer_if;
    logic [7:0] m_data;
    logic       m_sof;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_sof, output m_valid, input m_ready);
    modport slave  (input m_data, input m_sof, input m_valid, output m_ready);
endinterface

// File: rtl/hdlc_deframer.sv
// hdlc_deframer
// Recovers HDLC frames from the serial line bit stream: detects flags,
// stuffed zeros and aborts, removes stuffing, assembles LSB-first bytes and
// delivers them over a 2-entry valid/ready FIFO, with a status pulse per frame.
// Ports:
//   clk, areset_n     : clock, asynchronous active-low reset
//   in_valid, in      : line bit strobe and line bit
//   m (master)        : byte stream {m_data, m_sof, m_valid, m_ready}
//   frame_done        : one-cycle pulse at frame close or abort
//   frame_good        : qualifies frame_done
//   frame_len         : bytes of the closed frame, held until the next frame_done
//   det_state         : one-hot flag/stuff/abort detector state (debug)
`timescale 1ns/1ps

module hdlc_deframer #(
    parameter int MIN_BYTES = 4,
    parameter int LEN_W     = 12
) (
    input  logic               clk,
    input  logic               areset_n,
    input  logic               in_valid,
    input  logic               in,
    hdlc_deframer_if.master    m,
    output logic               frame_done,
    output logic               frame_good,
    output logic [LEN_W-1:0]   frame_len,
    output logic [9:0]         det_state
);

    // S0-S4: 0-4 ones, S5: five, S6: six, S7: abort, S8: stuffed zero, S9: flag
    typedef enum logic [9:0] {
        S0 = 10'b00_0000_0001,
        S1 = 10'b00_0000_0010,
        S2 = 10'b00_0000_0100,
        S3 = 10'b00_0000_1000,
        S4 = 10'b00_0001_0000,
        S5 = 10'b00_0010_0000,
        S6 = 10'b00_0100_0000,
        S7 = 10'b00_1000_0000,
        S8 = 10'b01_0000_0000,
        S9 = 10'b10_0000_0000
    } det_t;

    typedef enum logic {HUNT, FRAME} mode_t;

    det_t             det, det_next;
    mode_t            mode;
    logic [6:0]       dl;
    logic [2:0]       dl_cnt;
    logic [6:0]       asm_sr;
    logic [2:0]       bit_cnt;
    logic [LEN_W-1:0] byte_cnt;
    logic             overflow;

    logic             is_stuff, is_flag, is_abort, is_silent;
    logic             data_bit, pop_bit, push;
    logic [7:0]       push_byte;

    logic [8:0]       fifo_mem [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       fifo_cnt;
    logic             fifo_pop, push_ok, push_drop;

    always_comb begin
        det_next = S0;
        unique case (det)
            S0, S8, S9: det_next = in ? S1 : S0;
            S1:         det_next = in ? S2 : S0;
            S2:         det_next = in ? S3 : S0;
            S3:         det_next = in ? S4 : S0;
            S4:         det_next = in ? S5 : S0;
            S5:         det_next = in ? S6 : S8;
            S6:         det_next = in ? S7 : S9;
            S7:         det_next = in ? S7 : S0;
            default:    det_next = S0;
        endcase
    end

    assign is_stuff  = (det == S5) && !in;
    assign is_flag   = (det == S6) && !in;
    assign is_abort  = (det == S6) && in;
    assign is_silent = (det == S7) && in;

    // The 7-bit delay line holds back the bits that could turn out to be the
    // leading part of a closing flag; only bits older than that reach the
    // byte assembler.
    assign data_bit  = in_valid && (mode == FRAME) &&
                       !(is_stuff || is_flag || is_abort || is_silent);
    assign pop_bit   = data_bit && (dl_cnt == 3'd7);
    assign push      = pop_bit && (bit_cnt == 3'd7);
    assign push_byte = {dl[0], asm_sr};

    assign fifo_pop  = (fifo_cnt != 2'd0) && m.m_ready;
    assign push_ok   = push && ((fifo_cnt != 2'd2) || fifo_pop);
    assign push_drop = push && !push_ok;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            det        <= S0;
            mode       <= HUNT;
            dl         <= '0;
            dl_cnt     <= '0;
            asm_sr     <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
            frame_good <= 1'b0;
            frame_len  <= '0;
        end else begin
            frame_done <= 1'b0;
            if (in_valid) begin
                det <= det_next;
                if (mode == HUNT) begin
                    if (is_flag) begin
                        mode     <= FRAME;
                        dl_cnt   <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        overflow <= 1'b0;
                    end
                end else if (is_flag) begin
                    // Idle or shared flags close nothing.
                    if ((byte_cnt != '0) || (bit_cnt != 3'd0)) begin
                        frame_done <= 1'b1;
                        frame_good <= (bit_cnt == 3'd0) &&
                                      (byte_cnt >= LEN_W'(MIN_BYTES)) && !overflow;
                        frame_len  <= byte_cnt;
                    end
                    dl_cnt   <= '0;
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    overflow <= 1'b0;
                end else if (is_abort) begin
                    frame_done <= 1'b1;
                    frame_good <= 1'b0;
                    frame_len  <= byte_cnt;
                    mode       <= HUNT;
                    dl_cnt     <= '0;
                    bit_cnt    <= '0;
                    byte_cnt   <= '0;
                    overflow   <= 1'b0;
                end else if (data_bit) begin
                    dl <= {in, dl[6:1]};
                    if (dl_cnt != 3'd7) begin
                        dl_cnt <= dl_cnt + 3'd1;
                    end else begin
                        asm_sr  <= {dl[0], asm_sr[6:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_cnt != {LEN_W{1'b1}})
                                byte_cnt <= byte_cnt + 1'b1;
                            if (push_drop)
                                overflow <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Two-entry FIFO; a pop frees the slot for a push in the same cycle.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= '0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= {(byte_cnt == '0), push_byte};
                wr_ptr           <= ~wr_ptr;
            end
            if (fifo_pop)
                rd_ptr <= ~rd_ptr;
            case ({push_ok, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign m.m_valid = (fifo_cnt != 2'd0);
    assign m.m_data  = fifo_mem[rd_ptr][7:0];
    assign m.m_sof   = fifo_mem[rd_ptr][8];
    assign det_state = det;

endmodule

// File: tb/tb_hdlc_deframer.sv
// tb_hdlc_deframer
// Directed bench for hdlc_deframer: builds line bit streams (flags, stuffed
// bytes, aborts), records delivered bytes and frame status on the falling
// edge and compares them with hand-computed expectations.
`timescale 1ns/1ps

module tb_hdlc_deframer;

    localparam int LEN_W = 12;

    logic             clk = 1'b0;
    logic             areset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             frame_done, frame_good;
    logic [LEN_W-1:0] frame_len;
    logic [9:0]       det_state;

    hdlc_deframer_if sif ();

    hdlc_deframer #(.MIN_BYTES(4), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .areset_n   (areset_n),
        .in_valid   (in_valid),
        .in         (in_bit),
        .m          (sif),
        .frame_done (frame_done),
        .frame_good (frame_good),
        .frame_len  (frame_len),
        .det_state  (det_state)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    logic [8:0]       rx_q [$];
    int               done_cnt = 0;
    logic             last_good = 1'b0;
    logic [LEN_W-1:0] last_len = '0;
    int               ones_run = 0;
    bit               gap_mode = 1'b0;

    // A handshake seen on the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (areset_n) begin
            if (sif.m_valid && sif.m_ready)
                rx_q.push_back({sif.m_sof, sif.m_data});
            if (frame_done) begin
                done_cnt  = done_cnt + 1;
                last_good = frame_good;
                last_len  = frame_len;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b);
        int n;
        if (gap_mode) begin
            n = $urandom_range(0, 2);
            in_valid = 1'b0;
            repeat (n) tick();
        end
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_flag();
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) send_bit(f[i]);
        ones_run = 0;
    endtask

    // Sends n bits LSB first with transmitter zero stuffing.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(b[i]);
            if (b[i]) begin
                ones_run++;
                if (ones_run == 5) begin
                    send_bit(1'b0);
                    ones_run = 0;
                end
            end else begin
                ones_run = 0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        areset_n = 1'b0;
        tick();
        tick();
        areset_n = 1'b1;
        tick();
        ones_run = 0;
    endtask

    task automatic test_reset();
        int rb, db;
        areset_n = 1'b0;
        sif.m_ready = 1'b0;
        tick();
        checks++;
        if (det_state !== 10'h001) begin
            errors++;
            $display("[TB] FAIL reset_det: got %h expected 001", det_state);
        end
        checks++;
        if (sif.m_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: m_valid=%b frame_done=%b expected 0/0", sif.m_valid, frame_done);
        end
        areset_n = 1'b1;
        tick();
        db = done_cnt;
        send_flag();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_bits(8'h05, 3);
        checks++;
        if (sif.m_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midframe_valid: got %b expected 1", sif.m_valid);
        end
        areset_n = 1'b0;
        #2;
        checks++;
        if (sif.m_valid !== 1'b0 || det_state !== 10'h001) begin
            errors++;
            $display("[TB] FAIL async_reset: m_valid=%b det=%h expected 0/001", sif.m_valid, det_state);
        end
        tick();
        areset_n = 1'b1;
        idle(10);
        checks++;
        if (done_cnt != db || frame_len !== '0 || sif.m_data !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_discard: done=%0d len=%0d data=%h expected 0/0/00", done_cnt - db, frame_len, sif.m_data);
        end
        sif.m_ready = 1'b1;
        rb = rx_q.size();
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h0F);
        idle(5);
        checks++;
        if (rx_q.size() != rb || done_cnt != db) begin
            errors++;
            $display("[TB] FAIL hunt_ignore: bytes=%0d done=%0d expected 0/0", rx_q.size() - rb, done_cnt - db);
        end
    endtask

    task automatic test_basic_frame(input bit gaps);
        logic [8:0] exp [4];
        logic [9:0] det_snap;
        int rb, db;
        exp = '{9'h101, 9'h002, 9'h003, 9'h004};
        do_reset();
        sif.m_ready = 1'b1;
        gap_mode = gaps;
        rb = rx_q.size();
        db = done_cnt;
        send_flag();
        send_byte(8'h01);
        if (gaps) begin
            det_snap = det_state;
            idle(4);
            checks++;
            if (det_state !== det_snap) begin
                errors++;
                $display("[TB] FAIL gap_freeze: got %h expected %h", det_state, det_snap);
            end
        end
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        send_flag();
        gap_mode = 1'b0;
        idle(10);
        checks++;
        if (rx_q.size() - rb != 4) begin
            errors++;
            $display("[TB] FAIL basic_count gaps=%0d: got %0d expected 4", gaps, rx_q.size() - rb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_q[rb + i] !== exp[i]) begin
                    errors++;
                    $display("[TB] FAIL basic_byte%0d gaps=%0d: got %h expected %h", i, gaps, rx_q[rb + i], exp[i]);
                end
            end
        end
        checks++;
        if (done_cnt - db != 1 || last_good !== 1'b1 || last_len !== 12'd4) begin
            errors++;
            $display("[TB] FAIL basic_status gaps=%0d: done=%0d good=%b len=%0d expected 1/1/4", gaps, done_cnt - db, last_good, last_len);
        end
        checks++;
        if (frame_len !== 12'd4) begin
            errors++;
            $display("[TB] FAIL basic_len_hold: got %0d expected 4", frame_len);
        end
    endtask

    task automatic test_stuffing();
        logic [8:0] exp [4];
        int rb, db;
        exp = '{9'h1FF, 9'h0FF, 9'h07E, 9'h000};
        do_reset();
        sif.m_ready = 1'b1;
        rb = rx_q.size();
        db = done_cnt;
        send_flag();
        send_byte(8'hFF);
        send_byte(8'hFF);
        send_byte(8'h7E);
        send_byte(8'h00);
        send_flag();
        idle(10);
        checks++;
        if (rx_q.size() - rb != 4) begin
            errors++;
            $display("[TB] FAIL stuff_count: got %0d expected 4", rx_q.size() - rb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_q[rb + i] !== exp[i]) begin
                    errors++;
                    $display("[TB] FAIL stuff_byte%0d: got %h expected %h", i, rx_q[rb + i], exp[i]);
                end
            end
        end
        checks++;
        if (done_cnt - db != 1 || last_good !== 1'b1 || last_len !== 12'd4) begin
            errors++;
            $display("[TB] FAIL stuff_status: done=%0d good=%b len=%0d expected 1/1/4", done_cnt - db, last_good, last_len);
        end
    endtask

    task automatic test_abort();
        logic [8:0] exp [4];
        int rb, db;
        exp = '{9'h1A1, 9'h0B2, 9'h0C3, 9'h0D4};
        do_reset();
        sif.m_ready = 1'b1;
        db = done_cnt;
        send_flag();
        send_byte(8'hA5);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        ones_run = 0;
        idle(3);
        checks++;
        if (done_cnt - db != 1 || last_good !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_status: done=%0d good=%b expected 1/0", done_cnt - db, last_good);
        end
        checks++;
        if (det_state !== 10'h080) begin
            errors++;
            $display("[TB] FAIL abort_det: got %h expected 080", det_state);
        end
        rb = rx_q.size();
        db = done_cnt;
        send_byte(8'h12);
        send_byte(8'h34);
        idle(5);
        checks++;
        if (rx_q.size() != rb || done_cnt != db) begin
            errors++;
            $display("[TB] FAIL abort_hunt: bytes=%0d done=%0d expected 0/0", rx_q.size() - rb, done_cnt - db);
        end
        send_flag();
        send_byte(8'hA1);
        send_byte(8'hB2);
        send_byte(8'hC3);
        send_byte(8'hD4);
        send_flag();
        idle(10);
        checks++;
        if (rx_q.size() - rb != 4) begin
            errors++;
            $display("[TB] FAIL recover_count: got %0d expected 4", rx_q.size() - rb);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rx_q[rb + i] !== exp[i]) begin
                    errors++;
                    $display("[TB] FAIL recover_byte%0d: got %h expected %h", i, rx_q[rb + i], exp[i]);
                end
            end
        end
        checks++;
        if (done_cnt - db != 1 || last_good !== 1'b1 || last_len !== 12'd4) begin
            errors++;
            $display("[TB] FAIL recover_status: done=%0d good=%b len=%0d expected 1/1/4", done_cnt - db, last_good, last_len);
        end
    endtask

    task automatic test_length();
        int db;
        do_reset();
        sif.m_ready = 1'b1;
        db = done_cnt;
        send_flag();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_flag();
        idle(5);
        checks++;
        if (done_cnt - db != 1 || last_good !== 1'b0 || last_len !== 12'd3) begin
            errors++;
            $display("[TB] FAIL short_frame: done=%0d good=%b len=%0d expected 1/0/3", done_cnt - db, last_good, last_len);
        end
        db = done_cnt;
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h77);
        send_bits(8'h05, 4);
        send_flag();
        idle(5);
        checks++;
        if (done_cnt - db != 1 || last_good !== 1'b0 || last_len !== 12'd4) begin
            errors++;
            $display("[TB] FAIL misaligned_frame: done=%0d good=%b len=%0d expected 1/0/4", done_cnt - db, last_good, last_len);
        end
    endtask

    task automatic test_backpressure();
        int rb, db;
        do_reset();
        sif.m_ready = 1'b0;
        rb = rx_q.size();
        db = done_cnt;
        send_flag();
        send_byte(8'h3C);
        send_byte(8'h5A);
        checks++;
        if (sif.m_valid !== 1'b1 || sif.m_data !== 8'h3C || sif.m_sof !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_head_early: valid=%b data=%h sof=%b expected 1/3C/1", sif.m_valid, sif.m_data, sif.m_sof);
        end
        send_byte(8'h96);
        send_byte(8'hE1);
        send_flag();
        idle(5);
        checks++;
        if (sif.m_valid !== 1'b1 || sif.m_data !== 8'h3C || sif.m_sof !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_head_late: valid=%b data=%h sof=%b expected 1/3C/1", sif.m_valid, sif.m_data, sif.m_sof);
        end
        checks++;
        if (done_cnt - db != 1 || last_good !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_status: done=%0d good=%b expected 1/0", done_cnt - db, last_good);
        end
        sif.m_ready = 1'b1;
        idle(6);
        checks++;
        if (rx_q.size() - rb != 2) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d expected 2", rx_q.size() - rb);
        end else begin
            checks++;
            if (rx_q[rb] !== 9'h13C || rx_q[rb + 1] !== 9'h05A) begin
                errors++;
                $display("[TB] FAIL bp_bytes: got %h %h expected 13C 05A", rx_q[rb], rx_q[rb + 1]);
            end
        end
        checks++;
        if (sif.m_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_drained: got %b expected 0", sif.m_valid);
        end
    endtask

    task automatic test_back_to_back();
        int rb, db;
        do_reset();
        sif.m_ready = 1'b1;
        rb = rx_q.size();
        db = done_cnt;
        send_flag();
        send_flag();
        send_flag();
        idle(5);
        checks++;
        if (done_cnt != db || rx_q.size() != rb) begin
            errors++;
            $display("[TB] FAIL flags_idle: done=%0d bytes=%0d expected 0/0", done_cnt - db, rx_q.size() - rb);
        end
        checks++;
        if (det_state !== 10'h200) begin
            errors++;
            $display("[TB] FAIL flags_det: got %h expected 200", det_state);
        end
    endtask

    initial begin
        sif.m_ready = 1'b0;
        test_reset();
        test_basic_frame(1'b0);
        test_stuffing();
        test_abort();
        test_length();
        test_backpressure();
        test_back_to_back();
        test_basic_frame(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
